spi_master_buffered: RTL and testbench
======================================

// Module: spi_master_buffered
// PURPOSE
//  Parametrised SPI master with on-chip TX/RX word buffers, runtime-selectable SPI mode (CPOL/CPHA)
//  and programmable transfer length. Successor to the fixed 8-bit, mode-0 IO module: the host loads
//  up to DEPTH words, pulses start, and reads the captured MISO words back after done. It sits between
//  the system bus / test sequencer and external SPI slave devices.
// PARAMETERS
//  DATA_WIDTH  8  bits per SPI word; shifted MSB first; >=2
//  DEPTH       4  words per TX and RX buffer; power of 2, >=2; AW=$clog2(DEPTH)
//  CLK_DIV     4  sysClk cycles per SPI half-period; also the CS setup and CS hold time; >=1
// PORTS
//  sysClk   in   1           system clock; all logic on its rising edge
//  reset    in   1           synchronous, active-high reset
//  tx_wr    in   1           write strobe: tx_buf[tx_addr] <= tx_data
//  tx_addr  in   AW          TX buffer write index
//  tx_data  in   DATA_WIDTH  TX write data
//  rx_addr  in   AW          RX buffer read index
//  rx_data  out  DATA_WIDTH  registered rx_buf[rx_addr]; 1-cycle read latency
//  len      in   AW+1        words per transaction; sampled on accepted start
//  mode     in   2           {CPOL,CPHA}; sampled on accepted start
//  start    in   1           1-cycle pulse; begins a transaction when idle
//  busy     out  1           high from the cycle after start is accepted until done
//  done     out  1           1-cycle completion pulse
//  spiClk   out  1           SPI clock; idles at the latched CPOL
//  mosi     out  1           serial data to slave
//  miso     in   1           serial data from slave
//  cs       out  1           active-low chip select
// BEHAVIOUR
//  Reset: cs=1, spiClk=0, mosi=0, busy=0, done=0, rx_data=0, latched mode=00, FSM=IDLE.
//    Buffer contents are not cleared.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
//  IDLE:  start=1 is accepted. Latch mode and len; len>DEPTH clamps to DEPTH. spiClk<=CPOL.
//    len==0 -> go to DONE directly (no cs activity). Otherwise cs<=0, busy<=1, word index=0,
//    mosi<=tx_buf[0] MSB when CPHA=0.
//  SETUP: CLK_DIV cycles with cs low and spiClk idle, then SHIFT.
//  SHIFT: spiClk toggles every CLK_DIV cycles; 2*DATA_WIDTH edges per word.
//    CPHA=0: sample miso on leading edges, drive next bit on trailing edges.
//    CPHA=1: drive bit on leading edges, sample on trailing edges.
//    After the last edge of a word: rx_buf[index]<=shift register, index++.
//    Words are back-to-back with no gap and cs stays low. After word len-1 -> HOLD.
//  HOLD:  CLK_DIV cycles with spiClk at CPOL, then cs<=1 -> DONE.
//  DONE:  done=1 for exactly one cycle, busy<=0 -> IDLE.
//  Latency (len>=1): cs low for CLK_DIV*(2 + 2*DATA_WIDTH*len) cycles; done rises 1 cycle after cs rises.
//  start while not IDLE is ignored. tx_wr while busy is ignored (TX buffer frozen during transfer).
//  rx_data reads are allowed at any time; a read of the word being written in the same cycle
//    returns the old value.
//  mosi after the final bit holds its last value until the next transaction.
//  Reset asserted mid-transfer: next cycle all outputs take reset values and no done pulse is issued.
//    rx_buf holds any words already completed.
// TESTING  (DATA_WIDTH=8, DEPTH=4, CLK_DIV=2)
//  1. Loopback (miso=mosi): write 41,00,0A,00; len=4, mode=00, start -> rx 41,00,0A,00; cs low 132 cycles;
//     exactly one done pulse.
//  2. Slave model returning A5 in modes 01, 10, 11 with len=1 -> rx_buf[0]=A5; spiClk idle = CPOL
//     before and after the transfer.
//  3. len=0 -> done 1 cycle after start, cs stays 1. len=7 -> clamps to 4 words (132-cycle cs window).
//  4. start and tx_wr (addr 0, data FF) pulsed mid-transfer -> no restart; tx_buf[0] unchanged;
//     a second run returns the original data.
//  5. reset asserted during word 2 -> cs=1, spiClk=0, busy=0 next cycle; no done; rx_buf[0..1] retained.

Source files
------------

// File: rtl/spi_master_buffered.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_buffered
// Brief   : SPI master with TX/RX word buffers, runtime CPOL/CPHA, variable length.
// Revision: 1.0
// ============================================================================
module spi_master_buffered #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CLK_DIV    = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  sysClk,
  input  logic                  reset,
  input  logic                  tx_wr,
  input  logic [AW-1:0]         tx_addr,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [AW-1:0]         rx_addr,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic [AW:0]           len,
  input  logic [1:0]            mode,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  spiClk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs
);

  localparam int DIVW = $clog2(CLK_DIV + 1);
  localparam int BW   = $clog2(DATA_WIDTH);
  localparam logic [DIVW-1:0] c_DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [BW-1:0]   c_BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0]     c_DEPTH    = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_tx_buf [DEPTH];
  logic [DATA_WIDTH-1:0] r_rx_buf [DEPTH];
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic [DATA_WIDTH-1:0] r_rx_sh;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic [DIVW-1:0]       r_div;
  logic [BW-1:0]         r_bit;
  logic [AW-1:0]         r_word;
  logic [AW:0]           r_len;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_cs;
  logic                  r_spiClk;
  logic                  r_mosi;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_div_end;
  logic                  w_lead;
  logic                  w_last_bit;
  logic                  w_last_word;
  logic [AW:0]           w_len_clamped;
  logic [AW-1:0]         w_word_nxt;
  logic [DATA_WIDTH-1:0] w_rx_next;
  logic [DATA_WIDTH-1:0] w_tx_next;

  assign w_div_end     = (r_div == c_DIV_LAST);
  // A leading edge is the toggle that moves spiClk away from its idle level.
  assign w_lead        = (r_spiClk == r_cpol);
  assign w_last_bit    = (r_bit == c_BIT_LAST);
  assign w_last_word   = ({1'b0, r_word} == (r_len - (AW+1)'(1)));
  assign w_len_clamped = (len > c_DEPTH) ? c_DEPTH : len;
  assign w_word_nxt    = r_word + AW'(1);
  assign w_rx_next     = {r_rx_sh[DATA_WIDTH-2:0], miso};
  assign w_tx_next     = r_tx_buf[w_word_nxt];

  // TX buffer is frozen while a transfer is in flight.
  always_ff @(posedge sysClk) begin
    if (tx_wr && !r_busy) r_tx_buf[tx_addr] <= tx_data;
  end

  always_ff @(posedge sysClk) begin
    if (reset) r_rx_data <= '0;
    else       r_rx_data <= r_rx_buf[rx_addr];
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cs     <= 1'b1;
      r_spiClk <= 1'b0;
      r_mosi   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_word   <= '0;
      r_len    <= '0;
      r_tx_sh  <= '0;
      r_rx_sh  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cpol   <= mode[1];
            r_cpha   <= mode[0];
            r_len    <= w_len_clamped;
            r_spiClk <= mode[1];
            r_div    <= '0;
            r_bit    <= '0;
            r_word   <= '0;
            r_tx_sh  <= r_tx_buf[0];
            if (w_len_clamped == '0) begin
              r_state <= S_DONE;
            end else begin
              r_cs    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_SETUP;
              if (!mode[0]) r_mosi <= r_tx_buf[0][DATA_WIDTH-1];
            end
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_div <= r_div + DIVW'(1);
          end
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_div    <= '0;
            r_spiClk <= ~r_spiClk;
            if (w_lead) begin
              if (r_cpha) begin
                r_mosi  <= r_tx_sh[DATA_WIDTH-1];
                r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
              end else begin
                r_rx_sh <= w_rx_next;
              end
            end else begin
              if (r_cpha) r_rx_sh <= w_rx_next;
              if (w_last_bit) begin
                r_rx_buf[r_word] <= r_cpha ? w_rx_next : r_rx_sh;
                r_bit  <= '0;
                r_word <= w_word_nxt;
                if (w_last_word) begin
                  r_state <= S_HOLD;
                end else begin
                  r_tx_sh <= w_tx_next;
                  if (!r_cpha) r_mosi <= w_tx_next[DATA_WIDTH-1];
                end
              end else begin
                r_bit <= r_bit + BW'(1);
                if (!r_cpha) begin
                  r_mosi  <= r_tx_sh[DATA_WIDTH-2];
                  r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
                end
              end
            end
          end else begin
            r_div <= r_div + DIVW'(1);
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_cs    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_div <= r_div + DIVW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_data = r_rx_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign spiClk  = r_spiClk;
  assign mosi    = r_mosi;
  assign cs      = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_buffered.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_master_buffered
// Brief   : Directed self-checking bench for spi_master_buffered (8-bit, 4-deep, CLK_DIV=2).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_spi_master_buffered;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CLK_DIV = 2;
  localparam int AW = 2;

  logic          sysClk = 1'b0;
  logic          reset = 1'b1;
  logic          tx_wr = 1'b0;
  logic [AW-1:0] tx_addr = '0;
  logic [DW-1:0] tx_data = '0;
  logic [AW-1:0] rx_addr = '0;
  logic [DW-1:0] rx_data;
  logic [AW:0]   len = '0;
  logic [1:0]    mode = '0;
  logic          start = 1'b0;
  logic          busy, done, spiClk, mosi, miso, cs;

  logic          loopback = 1'b1;
  logic          sl_bit = 1'b0;
  logic          sl_prev = 1'b0;
  logic [7:0]    sl_data = 8'hA5;
  int            sl_cnt = 0;

  int            n_cmp = 0;
  int            n_bad = 0;

  assign miso = loopback ? mosi : sl_bit;

  always #5 sysClk = ~sysClk;

  spi_master_buffered #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .sysClk(sysClk), .reset(reset), .tx_wr(tx_wr), .tx_addr(tx_addr), .tx_data(tx_data),
    .rx_addr(rx_addr), .rx_data(rx_data), .len(len), .mode(mode), .start(start),
    .busy(busy), .done(done), .spiClk(spiClk), .mosi(mosi), .miso(miso), .cs(cs)
  );

  // Slave returning sl_data MSB first; shifts on trailing (CPHA=0) or leading (CPHA=1) edges.
  always @(negedge sysClk) begin
    if (cs) begin
      sl_cnt  <= 0;
      sl_prev <= mode[1];
      sl_bit  <= sl_data[7];
    end else if (spiClk != sl_prev) begin
      sl_prev <= spiClk;
      sl_cnt  <= sl_cnt + 1;
      if (mode[0]) begin
        if (sl_cnt % 2 == 0) sl_bit <= sl_data[7 - sl_cnt / 2];
      end else begin
        if (sl_cnt % 2 == 1 && (sl_cnt + 1) / 2 < 8) sl_bit <= sl_data[7 - (sl_cnt + 1) / 2];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_tx(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge sysClk);
    tx_wr = 1'b1; tx_addr = a; tx_data = d;
    @(negedge sysClk);
    tx_wr = 1'b0;
  endtask

  task automatic read_rx(input logic [AW-1:0] a, output logic [DW-1:0] v);
    @(negedge sysClk);
    rx_addr = a;
    @(negedge sysClk);
    v = rx_data;
  endtask

  task automatic run_txn(input logic [AW:0] l, input logic [1:0] m, input int inj_at, input int rst_at,
                         output int cs_low, output int n_done, output int done_at, output int rise_at,
                         output logic clk_first, output logic clk_after);
    bit seen_low;
    cs_low = 0; n_done = 0; done_at = -1; rise_at = -1;
    clk_first = 1'b0; clk_after = 1'b0; seen_low = 1'b0;
    @(negedge sysClk);
    len = l; mode = m;
    @(negedge sysClk);
    start = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge sysClk);
      start = 1'b0; tx_wr = 1'b0; reset = 1'b0;
      if (i == inj_at) begin
        start = 1'b1; tx_wr = 1'b1; tx_addr = '0; tx_data = 8'hFF;
      end
      if (i == rst_at) reset = 1'b1;
      if (i == rst_at + 1) begin
        check("rst_mid_cs", cs, 1);
        check("rst_mid_spiClk", spiClk, 0);
        check("rst_mid_busy", busy, 0);
      end
      if (!cs) begin
        cs_low++;
        if (!seen_low) begin
          seen_low = 1'b1;
          clk_first = spiClk;
        end
      end else if (seen_low && rise_at < 0) begin
        rise_at = i;
      end
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = i;
          clk_after = spiClk;
        end
      end
      if (done_at >= 0 && i >= done_at + 4) break;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    logic [1:0] m;
    int cs_low, nd, da, ra;
    logic cf, ca;

    repeat (3) @(negedge sysClk);
    check("reset_cs", cs, 1);
    check("reset_spiClk", spiClk, 0);
    check("reset_mosi", mosi, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rx_data", rx_data, 0);
    @(negedge sysClk);
    reset = 1'b0;

    // Loopback, four words, mode 0
    write_tx(0, 8'h41); write_tx(1, 8'h00); write_tx(2, 8'h0A); write_tx(3, 8'h00);
    loopback = 1'b1;
    run_txn(3'd4, 2'b00, -1, -1, cs_low, nd, da, ra, cf, ca);
    check("loop_cs_low", cs_low, 132);
    check("loop_done_cnt", nd, 1);
    check("loop_done_after_cs", da - ra, 1);
    read_rx(0, v); check("loop_rx0", v, 8'h41);
    read_rx(1, v); check("loop_rx1", v, 8'h00);
    read_rx(2, v); check("loop_rx2", v, 8'h0A);
    read_rx(3, v); check("loop_rx3", v, 8'h00);

    // Slave returning A5 in the other three modes
    loopback = 1'b0;
    for (int k = 1; k < 4; k++) begin
      m = 2'(k);
      run_txn(3'd1, m, -1, -1, cs_low, nd, da, ra, cf, ca);
      read_rx(0, v);
      check($sformatf("mode%0d_rx0", k), v, 8'hA5);
      check($sformatf("mode%0d_cs_low", k), cs_low, 36);
      check($sformatf("mode%0d_clk_before", k), cf, m[1]);
      check($sformatf("mode%0d_clk_after", k), ca, m[1]);
    end

    // Zero length and clamped length
    loopback = 1'b1;
    run_txn(3'd0, 2'b00, -1, -1, cs_low, nd, da, ra, cf, ca);
    check("len0_cs_low", cs_low, 0);
    check("len0_done_cnt", nd, 1);
    check("len0_done_at", da, 2);
    run_txn(3'd7, 2'b00, -1, -1, cs_low, nd, da, ra, cf, ca);
    check("len7_cs_low", cs_low, 132);
    check("len7_done_cnt", nd, 1);
    read_rx(0, v); check("len7_rx0", v, 8'h41);

    // start and tx_wr mid-transfer are ignored
    run_txn(3'd4, 2'b00, 40, -1, cs_low, nd, da, ra, cf, ca);
    check("inj_cs_low", cs_low, 132);
    check("inj_done_cnt", nd, 1);
    read_rx(0, v); check("inj_rx0", v, 8'h41);
    run_txn(3'd4, 2'b00, -1, -1, cs_low, nd, da, ra, cf, ca);
    read_rx(0, v); check("rerun_rx0", v, 8'h41);
    read_rx(2, v); check("rerun_rx2", v, 8'h0A);

    // Reset during word 2
    write_tx(0, 8'h3C); write_tx(1, 8'hC3); write_tx(2, 8'h77); write_tx(3, 8'h88);
    run_txn(3'd4, 2'b10, -1, 80, cs_low, nd, da, ra, cf, ca);
    check("rst_done_cnt", nd, 0);
    check("rst_cs_low", cs_low, 80);
    read_rx(0, v); check("rst_rx0", v, 8'h3C);
    read_rx(1, v); check("rst_rx1", v, 8'hC3);
    read_rx(2, v); check("rst_rx2", v, 8'h0A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
